instr_fetch_queue: RTL
======================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning the width of address and instruction words.
REQ-002 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries; legal values are powers of 2 from 2 to 16.
REQ-003 SHALL have parameter KTEXT_VEC, default 32'h80000180, meaning the exception vector address.
REQ-004 SHALL have ports iCLK in 1 (clock) and iRST in 1 (reset, synchronous, active-high).
REQ-005 SHALL have port iInitialPC in ADDR_W, meaning the PC loaded on reset.
REQ-006 SHALL have ports oMemReq out 1, oMemAddr out ADDR_W, iMemAck in 1 and iMemData in ADDR_W, forming the instruction memory handshake.
REQ-007 SHALL have ports oInstrValid out 1, oInstr out ADDR_W, oInstrPC out ADDR_W and iInstrTake in 1, forming the queue-head handshake toward decode.
REQ-008 SHALL have ports iRedirect in 1 and iRedirectPC in ADDR_W, meaning a branch, jump or eret target.
REQ-009 SHALL have port iExc in 1, meaning an exception request (present only with the macro, see REQ-026).
REQ-010 SHALL have port oEPC out ADDR_W, meaning the captured exception PC (present only with the macro, see REQ-026).
REQ-011 SHALL have port oCount out $clog2(DEPTH)+1, meaning the number of valid queue entries.

Function
REQ-012 SHALL implement fetch FSM states IDLE, WAIT and DROP.
- IDLE->WAIT when count + 0 < DEPTH and no flush is active; oMemReq=1 and oMemAddr=fetch PC.
REQ-013 SHALL keep oMemReq and oMemAddr stable in WAIT until iMemAck, with at most one request outstanding.
REQ-014 SHALL, on iMemAck in WAIT, write {iMemData, fetch PC} to the queue tail, advance fetch PC by 4 (mod 2^ADDR_W, wrapping silently), and go to IDLE.
- If space remains, the FSM SHALL reissue in the same cycle, giving back-to-back requests.
REQ-015 SHALL present data acked in cycle N at the queue head with oInstrValid=1 in cycle N+1 when the queue was empty.
REQ-016 SHALL pop the head on iInstrTake && oInstrValid; iInstrTake while empty SHALL be ignored.
REQ-017 SHALL leave oCount unchanged on a simultaneous push and pop, including when full.
REQ-018 SHALL issue no request when the queue is full (oCount==DEPTH).
REQ-019 SHALL, on iRedirect, flush the queue (oCount=0 next cycle), set fetch PC = {iRedirectPC[ADDR_W-1:2],2'b00}, and ignore iInstrTake in that cycle.
REQ-020 SHALL, on a redirect in WAIT without ack, go to DROP; DROP SHALL discard the next iMemAck, then go to IDLE, with oMemReq held at its old address until that ack.
REQ-021 SHALL, on a redirect in the same cycle as iMemAck, discard the acked data and go to IDLE.
REQ-022 SHALL leave oInstr and oInstrPC undefined when oInstrValid=0; the bench SHALL not check them then.

Reset
REQ-023 SHALL, while iRST is sampled high, set fetch PC=iInitialPC, oCount=0, oInstrValid=0, state=IDLE, oMemReq=0 and oEPC=0.
REQ-024 SHALL ignore an ack arriving after a reset that aborted a WAIT (state IDLE, no outstanding request).
REQ-025 SHALL issue the first request in the first cycle after iRST deasserts.

Configuration
REQ-026 SHALL use macro FETCH_EXC_VECTOR_EN to compile exception handling in or out.
- Defined: iExc has priority over iRedirect; it flushes like REQ-019/020 with target KTEXT_VEC, and loads oEPC with oInstrPC if oInstrValid, else the fetch PC.
- oEPC SHALL hold its value between exceptions.
- Undefined: the iExc and oEPC ports and the EPC register SHALL be absent.

Verification
REQ-027 SHALL check reset and stream: iInitialPC=0x00400000 with ack one cycle after each request -> oMemAddr 0x00400000, 0x00400004, ...; first oInstrValid two cycles after the first request.
REQ-028 SHALL check full queue: DEPTH=4 with iInstrTake=0 -> oCount=4 and oMemReq=0; one take -> next oMemAddr is 0x00400010.
REQ-029 SHALL check redirect during WAIT: iRedirect with iRedirectPC=0x00400103 while the ack is delayed 3 cycles -> late ack data dropped, oCount=0, next request at 0x00400100.
REQ-030 SHALL check wrap-around: iInitialPC=0xFFFFFFFC -> second request at 0x00000000.
REQ-031 SHALL check simultaneous events (macro defined): iExc and iRedirect in the same cycle with head PC 0x00400008 -> oEPC=0x00400008 and next request at 0x80000180.
REQ-032 SHALL check reset mid-WAIT: iRST for one cycle, then a stray iMemAck -> oCount stays 0, and the first request goes to iInitialPC.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: single-outstanding fetch FSM (IDLE/WAIT/DROP) feeding a DEPTH-entry FIFO.
// Optional exception vectoring and EPC capture are compiled in with FETCH_EXC_VECTOR_EN.
module instr_fetch_queue #(
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 4,
    parameter logic [ADDR_W-1:0] KTEXT_VEC = 32'h80000180
) (
    input  logic                   iCLK,
    input  logic                   iRST,
    input  logic [ADDR_W-1:0]      iInitialPC,
    output logic                   oMemReq,
    output logic [ADDR_W-1:0]      oMemAddr,
    input  logic                   iMemAck,
    input  logic [ADDR_W-1:0]      iMemData,
    output logic                   oInstrValid,
    output logic [ADDR_W-1:0]      oInstr,
    output logic [ADDR_W-1:0]      oInstrPC,
    input  logic                   iInstrTake,
    input  logic                   iRedirect,
    input  logic [ADDR_W-1:0]      iRedirectPC,
`ifdef FETCH_EXC_VECTOR_EN
    input  logic                   iExc,
    output logic [ADDR_W-1:0]      oEPC,
`endif
    output logic [$clog2(DEPTH):0] oCount
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP    = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(3));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } fetch_state_t;

    fetch_state_t      stateReg, stateNext;
    logic [ADDR_W-1:0] fetchPcReg, fetchPcNext;
    logic [ADDR_W-1:0] reqAddrReg, reqAddrNext;
    logic [PTR_W-1:0]  wrPtrReg, rdPtrReg;
    logic [PTR_W:0]    countReg;
    logic [ADDR_W-1:0] instrMem [DEPTH];
    logic [ADDR_W-1:0] pcMem    [DEPTH];

    logic              excReq;
    logic              flush;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] flushPc;

`ifdef FETCH_EXC_VECTOR_EN
    assign excReq = iExc;
`else
    assign excReq = 1'b0;
`endif

    // An exception outranks a redirect; redirect targets are forced word-aligned.
    assign flush       = iRedirect | excReq;
    assign flushPc     = excReq ? KTEXT_VEC : (iRedirectPC & ALIGN_MASK);
    assign oInstrValid = (countReg != '0);
    assign pop         = iInstrTake & oInstrValid & ~flush;

    always_comb begin
        stateNext   = stateReg;
        fetchPcNext = fetchPcReg;
        reqAddrNext = reqAddrReg;
        oMemReq     = 1'b0;
        push        = 1'b0;
        case (stateReg)
            IDLE: begin
                if (!flush && (countReg != FULL_COUNT)) begin
                    oMemReq     = 1'b1;
                    reqAddrNext = fetchPcReg;
                    stateNext   = WAIT;
                end
            end
            WAIT: begin
                oMemReq = 1'b1;
                if (flush) begin
                    stateNext = iMemAck ? IDLE : DROP;
                end else if (iMemAck) begin
                    push        = 1'b1;
                    fetchPcNext = fetchPcReg + PC_STEP;
                    stateNext   = IDLE;
                end
            end
            DROP: begin
                // Old request stays on the bus until memory answers; its data is discarded.
                oMemReq = 1'b1;
                if (iMemAck) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (flush) begin
            fetchPcNext = flushPc;
        end
        if (iRST) begin
            oMemReq = 1'b0;
        end
    end

    assign oMemAddr = (stateReg == IDLE) ? fetchPcReg : reqAddrReg;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stateReg   <= IDLE;
            fetchPcReg <= iInitialPC;
            reqAddrReg <= iInitialPC;
        end else begin
            stateReg   <= stateNext;
            fetchPcReg <= fetchPcNext;
            reqAddrReg <= reqAddrNext;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST || flush) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            if (push) begin
                wrPtrReg <= wrPtrReg + PTR_W'(1);
            end
            if (pop) begin
                rdPtrReg <= rdPtrReg + PTR_W'(1);
            end
            if (push && !pop) begin
                countReg <= countReg + (PTR_W+1)'(1);
            end else if (pop && !push) begin
                countReg <= countReg - (PTR_W+1)'(1);
            end
        end
    end

    // Storage needs no reset: entries are only observed once counted valid.
    always_ff @(posedge iCLK) begin
        if (push) begin
            instrMem[wrPtrReg] <= iMemData;
            pcMem[wrPtrReg]    <= fetchPcReg;
        end
    end

    assign oInstr   = instrMem[rdPtrReg];
    assign oInstrPC = pcMem[rdPtrReg];
    assign oCount   = countReg;

`ifdef FETCH_EXC_VECTOR_EN
    logic [ADDR_W-1:0] epcReg;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            epcReg <= '0;
        end else if (iExc) begin
            epcReg <= oInstrValid ? oInstrPC : fetchPcReg;
        end
    end

    assign oEPC = epcReg;
`endif

endmodule
